// File: rtl/tron_self_test.sv
// tron_self_test: replays stored instruction vectors into a DUT and scores its address, bus and regwrite responses
module tron_self_test #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 32,
  parameter int WAIT_W = 4,
  parameter int RST_CYC = 3,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [AW:0]       num_vec,
  input  logic              vec_we,
  input  logic [AW-1:0]     vec_addr,
  input  logic [DATA_W-1:0] vec_instr,
  input  logic [DATA_W-1:0] vec_exp_addr,
  input  logic [DATA_W-1:0] vec_exp_bus,
  input  logic [WAIT_W-1:0] vec_wait,
  input  logic [4:0]        vec_ctrl,
  input  logic [DATA_W-1:0] dut_address,
  input  logic [DATA_W-1:0] dut_bus,
  input  logic              dut_regwrite,
  output logic [DATA_W-1:0] dut_instruction,
  output logic              dut_reset,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       pass_count,
  output logic [AW:0]       fail_count,
  output logic              any_fail,
  output logic [AW-1:0]     first_fail
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_RST = 3'd2, S_WAIT = 3'd3, S_CHECK = 3'd4, S_DONE = 3'd5;
  localparam int RW = $clog2(RST_CYC + 1);
  localparam int CW = WAIT_W > RW ? WAIT_W : RW;
  localparam logic [AW:0] CNT_MAX = '1;
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  logic [DATA_W-1:0] r_mem_instr [DEPTH];
  logic [DATA_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_bus [DEPTH];
  logic [WAIT_W-1:0] r_mem_wait [DEPTH];
  logic [4:0]        r_mem_ctrl [DEPTH];
  logic [2:0]        r_state;
  logic [AW-1:0]     r_idx;
  logic [AW:0]       r_count;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_exp_addr;
  logic [DATA_W-1:0] r_exp_bus;
  logic [WAIT_W-1:0] r_wait;
  logic [3:0]        r_chk;
  logic [AW:0]       r_pass;
  logic [AW:0]       r_fail;
  logic              r_any;
  logic [AW-1:0]     r_first;
  logic              w_busy;
  logic              w_pass;
  logic              w_last;
  logic              w_start;
  logic [4:0]        w_ctrl;
  logic [WAIT_W-1:0] w_wait;
  assign w_busy = r_state == S_FETCH || r_state == S_RST || r_state == S_WAIT || r_state == S_CHECK;
  assign w_ctrl = r_mem_ctrl[r_idx];
  assign w_wait = r_mem_wait[r_idx];
  assign w_last = {1'b0, r_idx} == r_count - CNT_ONE;
  assign w_start = start && !abort;
  assign w_pass = (!r_chk[3] || dut_address == r_exp_addr) && (!r_chk[2] || dut_bus == r_exp_bus) && (!r_chk[1] || dut_regwrite == r_chk[0]);
  assign busy = w_busy;
  assign done = r_state == S_DONE;
  assign dut_reset = r_state == S_IDLE || r_state == S_RST;
  assign dut_instruction = (w_busy && r_state != S_FETCH) ? r_instr : '0;
  assign pass_count = r_pass;
  assign fail_count = r_fail;
  assign any_fail = r_any;
  assign first_fail = r_first;
  always_ff @(posedge clk)
    if (vec_we && !w_busy) begin
      r_mem_instr[vec_addr] <= vec_instr;
      r_mem_addr[vec_addr] <= vec_exp_addr;
      r_mem_bus[vec_addr] <= vec_exp_bus;
      r_mem_wait[vec_addr] <= vec_wait;
      r_mem_ctrl[vec_addr] <= vec_ctrl;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_count <= '0;
      r_cnt <= '0;
      r_instr <= '0;
      r_exp_addr <= '0;
      r_exp_bus <= '0;
      r_wait <= '0;
      r_chk <= '0;
      r_pass <= '0;
      r_fail <= '0;
      r_any <= 1'b0;
      r_first <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE:
          if (w_start) begin
            r_pass <= '0;
            r_fail <= '0;
            r_any <= 1'b0;
            r_first <= '0;
            r_idx <= '0;
            r_count <= num_vec > DEPTH_V ? DEPTH_V : num_vec;
            r_state <= num_vec == '0 ? S_DONE : S_FETCH;
          end
        S_FETCH: begin
          r_instr <= r_mem_instr[r_idx];
          r_exp_addr <= r_mem_addr[r_idx];
          r_exp_bus <= r_mem_bus[r_idx];
          r_wait <= w_wait;
          r_chk <= w_ctrl[3:0];
          r_cnt <= w_ctrl[4] ? CW'(RST_CYC - 1) : CW'(w_wait) - CW'(1);
          r_state <= abort ? S_IDLE : w_ctrl[4] ? S_RST : w_wait == '0 ? S_CHECK : S_WAIT;
        end
        S_RST: begin
          // the settle countdown is reloaded as the reset phase expires
          r_cnt <= r_cnt == '0 ? CW'(r_wait) - CW'(1) : r_cnt - CW'(1);
          r_state <= abort ? S_IDLE : r_cnt != '0 ? S_RST : r_wait == '0 ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          r_state <= abort ? S_IDLE : r_cnt == '0 ? S_CHECK : S_WAIT;
        end
        S_CHECK: begin
          if (w_pass)
            r_pass <= r_pass == CNT_MAX ? r_pass : r_pass + CNT_ONE;
          else begin
            r_fail <= r_fail == CNT_MAX ? r_fail : r_fail + CNT_ONE;
            r_any <= 1'b1;
            if (!r_any) r_first <= r_idx;
          end
          if (!w_last && !abort) r_idx <= r_idx + AW'(1);
          r_state <= abort ? S_IDLE : w_last ? S_DONE : S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_tron_self_test.sv
// tb_tron_self_test: directed vector table plus hand sequences against a toy DUT response model
module tb_tron_self_test;
  localparam int DW = 16;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  typedef struct {
    logic [15:0] instr;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [3:0]  wt;
    logic [4:0]  ctrl;
    int          lat;
    bit          ok;
  } vec_t;
  logic clk = 1'b0;
  logic reset, start, abort, vec_we;
  logic [AW:0] num_vec;
  logic [AW-1:0] vec_addr;
  logic [DW-1:0] vec_instr, vec_exp_addr, vec_exp_bus;
  logic [3:0] vec_wait;
  logic [4:0] vec_ctrl;
  logic [DW-1:0] dut_address, dut_bus, dut_instruction;
  logic dut_regwrite, dut_reset, busy, done, any_fail;
  logic [AW:0] pass_count, fail_count;
  logic [AW-1:0] first_fail;
  int n_chk = 0;
  int n_err = 0;
  vec_t tbl [7];
  tron_self_test dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .num_vec(num_vec),
    .vec_we(vec_we), .vec_addr(vec_addr), .vec_instr(vec_instr), .vec_exp_addr(vec_exp_addr),
    .vec_exp_bus(vec_exp_bus), .vec_wait(vec_wait), .vec_ctrl(vec_ctrl),
    .dut_address(dut_address), .dut_bus(dut_bus), .dut_regwrite(dut_regwrite),
    .dut_instruction(dut_instruction), .dut_reset(dut_reset), .busy(busy), .done(done),
    .pass_count(pass_count), .fail_count(fail_count), .any_fail(any_fail), .first_fail(first_fail)
  );
  always #5 clk = ~clk;
  // toy DUT: address = instr[11:8]; bus = bit15 ? 0xFF:instr[7:0] : instr[7:4]-instr[3:0]; regwrite = instr[12]
  always_comb begin
    dut_address = {12'h000, dut_instruction[11:8]};
    dut_bus = dut_instruction[15] ? {8'hFF, dut_instruction[7:0]} : {12'h000, dut_instruction[7:4]} - {12'h000, dut_instruction[3:0]};
    dut_regwrite = dut_instruction[12];
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wr(input int a, input logic [15:0] ins, input logic [15:0] ea, input logic [15:0] eb, input logic [3:0] w, input logic [4:0] c);
    vec_we = 1'b1;
    vec_addr = AW'(a);
    vec_instr = ins;
    vec_exp_addr = ea;
    vec_exp_bus = eb;
    vec_wait = w;
    vec_ctrl = c;
    step();
    vec_we = 1'b0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 5000) begin
      step();
      cyc++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask
  task automatic run(input int n, output int cyc);
    num_vec = (AW+1)'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc);
  endtask
  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    vec_we = 1'b0;
    num_vec = '0;
    vec_addr = '0;
    vec_instr = '0;
    vec_exp_addr = '0;
    vec_exp_bus = '0;
    vec_wait = '0;
    vec_ctrl = '0;
    tbl[0] = '{16'h0152, 16'h0001, 16'h0003, 4'd2, 5'b01100, 4, 1'b1};
    tbl[1] = '{16'h8093, 16'h0000, 16'hFF94, 4'd0, 5'b00100, 2, 1'b0};
    tbl[2] = '{16'h1000, 16'h0000, 16'h0000, 4'd1, 5'b00010, 3, 1'b0};
    tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 4'd1, 5'b00010, 3, 1'b1};
    tbl[4] = '{16'h0152, 16'h0002, 16'h0000, 4'd0, 5'b11000, 5, 1'b0};
    tbl[5] = '{16'hABCD, 16'h1111, 16'h2222, 4'd15, 5'b00000, 17, 1'b1};
    tbl[6] = '{16'h1234, 16'h0000, 16'h0000, 4'd2, 5'b10011, 7, 1'b1};
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dut_reset", dut_reset, 1);
    check("rst_instr", dut_instruction, 0);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);
    check("rst_any", any_fail, 0);
    check("rst_first", first_fail, 0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      wr(0, tbl[i].instr, tbl[i].ea, tbl[i].eb, tbl[i].wt, tbl[i].ctrl);
      run(1, cyc);
      check($sformatf("tbl%0d_lat", i), cyc, tbl[i].lat);
      check($sformatf("tbl%0d_pass", i), pass_count, {31'd0, tbl[i].ok});
      check($sformatf("tbl%0d_fail", i), fail_count, {31'd0, !tbl[i].ok});
      check($sformatf("tbl%0d_any", i), any_fail, {31'd0, !tbl[i].ok});
    end
    wr(0, 16'h0152, 16'h0001, 16'h0003, 4'd2, 5'b01100);
    wr(1, 16'h8093, 16'h0000, 16'hFF94, 4'd0, 5'b00100);
    wr(2, 16'h0241, 16'h0002, 16'h0003, 4'd1, 5'b01100);
    run(3, cyc);
    check("three_lat", cyc, 9);
    check("three_pass", pass_count, 2);
    check("three_fail", fail_count, 1);
    check("three_any", any_fail, 1);
    check("three_first", first_fail, 1);
    wr(0, 16'h0152, 16'h0000, 16'h0000, 4'd0, 5'b10000);
    num_vec = 6'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("trace%0d_dut_reset", i), dut_reset, (i >= 1 && i <= 3) ? 1 : 0);
      check($sformatf("trace%0d_busy", i), busy, 1);
      if (i == 1) check("trace_instr", dut_instruction, 16'h0152);
      step();
    end
    check("trace_done", done, 1);
    check("trace_done_dut_reset", dut_reset, 0);
    check("trace_done_instr", dut_instruction, 0);
    for (int k = 0; k < 5; k++) wr(k, 16'h0010 | 16'((k + 1) << 8), 16'(k + 1), 16'h0001, 4'd3, 5'b01100);
    num_vec = 6'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    check("abort_wait_instr", dut_instruction, 16'h0310);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dut_reset", dut_reset, 1);
    check("abort_pass", pass_count, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_clr", pass_count, 0);
    check("restart_busy", busy, 1);
    step();
    check("restart_idx0", dut_instruction, 16'h0110);
    wait_done(cyc);
    check("restart_lat", cyc, 24);
    check("restart_pass", pass_count, 5);
    wr(0, 16'h8093, 16'h0000, 16'hFF94, 4'd0, 5'b00100);
    num_vec = 6'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_chk_busy", busy, 0);
    check("abort_chk_done", done, 0);
    check("abort_chk_fail", fail_count, 1);
    check("abort_chk_any", any_fail, 1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_fail", fail_count, 1);
    run(1, cyc);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_in_done", done, 1);
    run(0, cyc);
    check("zero_lat", cyc, 0);
    check("zero_done", done, 1);
    check("zero_pass", pass_count, 0);
    check("zero_fail", fail_count, 0);
    check("zero_any", any_fail, 0);
    wr(0, 16'h0152, 16'h0001, 16'h0003, 4'd2, 5'b01100);
    for (int k = 1; k < DEPTH; k++) wr(k, 16'(k), 16'h0000, 16'h0000, 4'd0, 5'b00000);
    num_vec = 6'(DEPTH + 1);
    start = 1'b1;
    step();
    start = 1'b0;
    wr(0, 16'h0152, 16'h7777, 16'h0000, 4'd0, 5'b01000);
    wait_done(cyc);
    check("full_lat", cyc, 65);
    check("full_pass", pass_count, DEPTH);
    check("full_fail", fail_count, 0);
    run(1, cyc);
    check("busy_write_pass", pass_count, 1);
    check("busy_write_lat", cyc, 4);
    num_vec = 6'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_dut_reset", dut_reset, 1);
    check("async_instr", dut_instruction, 0);
    check("async_done", done, 0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tron_self_test.md
TRON_SELF_TEST -- requirements
Module: tron_self_test

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, which sets the width of instruction, address and bus fields.
REQ-002 The module SHALL have parameter DEPTH, default 32, which sets the number of vector slots, with AW = clog2(DEPTH).
REQ-003 The module SHALL have parameter WAIT_W, default 4, which sets the width of the per-vector wait count.
REQ-004 The module SHALL have parameter RST_CYC, default 3, which sets the number of DUT-reset cycles applied before a flagged vector (RST_CYC >= 1).
REQ-005 The module SHALL have the following ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  run request, pulse.
- abort  in  1  stop request, pulse.
- num_vec  in  AW+1  number of vectors to run.
- vec_we  in  1  vector write strobe.
- vec_addr  in  AW  vector slot to write.
- vec_instr  in  DATA_W  instruction to apply.
- vec_exp_addr  in  DATA_W  expected dut_address.
- vec_exp_bus  in  DATA_W  expected dut_bus.
- vec_wait  in  WAIT_W  settle cycles before the check.
- vec_ctrl  in  5  {rst_before, chk_addr, chk_bus, chk_rw, exp_rw}.
- dut_address  in  DATA_W  DUT address output.
- dut_bus  in  DATA_W  DUT bus output.
- dut_regwrite  in  1  DUT register-write strobe.
- dut_instruction  out  DATA_W  instruction driven to the DUT.
- dut_reset  out  1  reset driven to the DUT.
- busy  out  1  a run is in progress.
- done  out  1  run complete; level signal.
- pass_count  out  AW+1  vectors passed.
- fail_count  out  AW+1  vectors failed.
- any_fail  out  1  at least one vector failed.
- first_fail  out  AW  index of the first failing vector.

Function
REQ-006 The vector memory SHALL be written only when vec_we=1 and busy=0; writes while busy=1 SHALL be ignored, and memory contents SHALL NOT be reset.
REQ-007 The state machine SHALL have the states IDLE, FETCH, DUT_RST, WAIT, CHECK and DONE.
REQ-008 In IDLE or DONE, start=1 SHALL clear the counters, any_fail and first_fail, set the index to 0 and go to FETCH; if num_vec=0, it SHALL instead go to DONE with the counts at 0.
REQ-009 The effective vector count SHALL be min(num_vec, DEPTH), latched on start.
REQ-010 start while busy=1 SHALL be ignored.
REQ-011 FETCH SHALL last one cycle, perform a registered memory read, and transition to DUT_RST if rst_before=1 and to WAIT otherwise.
REQ-012 DUT_RST SHALL last exactly RST_CYC cycles with dut_reset=1.
REQ-013 WAIT SHALL last exactly vec_wait cycles, and vec_wait=0 SHALL go directly to CHECK.
REQ-014 dut_instruction SHALL equal the fetched instruction from the cycle after FETCH through CHECK, and SHALL be 0 in IDLE and DONE.
REQ-015 CHECK SHALL last one cycle and SHALL sample the DUT inputs in that cycle.
REQ-016 A vector SHALL pass when every enabled check matches: chk_addr compares dut_address to exp_addr, chk_bus compares dut_bus to exp_bus, and chk_rw compares dut_regwrite to exp_rw; a vector with no checks enabled SHALL pass.
REQ-017 On a pass, pass_count SHALL increment; on a fail, fail_count SHALL increment and any_fail SHALL be set, and on the first fail only, first_fail SHALL capture the index; both counters SHALL saturate at 2^(AW+1)-1.
REQ-018 After CHECK, the machine SHALL go to DONE if index = count-1, and otherwise SHALL increment the index and go to FETCH.
REQ-019 Per-vector latency SHALL be 1 + (rst_before ? RST_CYC : 0) + vec_wait + 1 cycles.
REQ-020 dut_reset SHALL be 1 in IDLE and DUT_RST and 0 in FETCH, WAIT, CHECK and DONE.
REQ-021 busy SHALL be 1 in FETCH, DUT_RST, WAIT and CHECK, and done SHALL be 1 only in DONE.
REQ-022 abort=1 in any busy state SHALL force IDLE on the next edge, leave done=0 and hold the counters; an abort in the same cycle as the final CHECK SHALL have priority, with that check's result still recorded.
REQ-023 abort in IDLE or DONE SHALL have no effect.
REQ-024 Simultaneous start and abort SHALL be resolved in favour of abort.

Reset
REQ-025 While reset=1, the module SHALL be in state IDLE with dut_reset=1, dut_instruction=0, busy=0, done=0, pass_count=0, fail_count=0, any_fail=0, first_fail=0 and index=0.
REQ-026 Reset asserted mid-run SHALL abandon the run immediately and asynchronously, and its deassertion SHALL leave the module in IDLE.

Verification
REQ-027 A bench SHALL cover: slot0 = {instr 0x0152, exp_addr 0x0001, exp_bus 0x0003, wait 2, chk_addr|chk_bus}, DUT model matching, num_vec=1 -> done after 4 cycles, pass_count=1, fail_count=0.
REQ-028 A bench SHALL cover: 3 vectors where slot1 expects bus 0xFF94 and the DUT returns 0xFF93 -> pass_count=2, fail_count=1, any_fail=1, first_fail=1.
REQ-029 A bench SHALL cover: rst_before=1, RST_CYC=3, wait=0 -> dut_reset high for exactly 3 cycles after FETCH and CHECK on the 5th cycle.
REQ-030 A bench SHALL cover: chk_rw=1 with exp_rw=0 (compare-style vector) and dut_regwrite=1 -> fail, and with dut_regwrite=0 -> pass.
REQ-031 A bench SHALL cover: abort during WAIT of vector 2 of 5 -> IDLE next cycle, done=0, pass_count=2; then start -> counters cleared and the run restarts from index 0.
REQ-032 A bench SHALL cover: num_vec=0 -> DONE in 1 cycle with counts 0; num_vec=DEPTH+1 -> exactly DEPTH checks performed; vec_we while busy -> memory unchanged.
